// File: rtl/mem_arbiter_pkg.sv
// Shared parameters and types for the memory arbiter slice.
// Holds the global widths (XLEN, INST_OP_WIDTH, ROB_SIZE_WIDTH), the memory
// op encodings, requester indices and the registered request-field bundle.
package mem_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int INST_OP_WIDTH  = 6;
  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [INST_OP_WIDTH-1:0] OP_NOP = 6'd0;
  localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd1;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd2;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd3;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd4;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd5;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd6;

  // Bit positions of each requester in a one-hot select vector.
  localparam int REQ_FET = 0;
  localparam int REQ_LSB = 1;
  localparam int REQ_ROB = 2;
  localparam int NUM_REQ = 3;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           addr;
    logic [XLEN-1:0]           val;
    logic [INST_OP_WIDTH-1:0]  op;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } arb_fields_t;

  // True when at most one bit of v is set.
  function automatic logic is_onehot0(input req_vec_t v);
    return (v & (v - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three memory requesters (fetch, load buffer, ROB),
// the arbiter and the memory controller.
// slave  : arbiter view (requests/controller status in, grants/enables out)
// master : requester + controller view (the opposite directions)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                      rdy;
  logic                      flush;

  logic                      fet_req;
  logic [XLEN-1:0]           fet_pc;

  logic                      lsb_req;
  logic [INST_OP_WIDTH-1:0]  lsb_op;
  logic [XLEN-1:0]           lsb_addr;
  logic [ROB_SIZE_WIDTH-1:0] lsb_id;

  logic                      rob_req;
  logic [INST_OP_WIDTH-1:0]  rob_op;
  logic [XLEN-1:0]           rob_addr;
  logic [XLEN-1:0]           rob_val;

  logic                      fet_gnt;
  logic                      lsb_gnt;
  logic                      rob_gnt;

  logic                      mc_busy;

  logic                      arb_fet_enable;
  logic                      arb_lsb_enable;
  logic                      arb_rob_enable;
  logic [XLEN-1:0]           arb_pc;
  logic [XLEN-1:0]           arb_addr;
  logic [XLEN-1:0]           arb_val;
  logic [INST_OP_WIDTH-1:0]  arb_op;
  logic [ROB_SIZE_WIDTH-1:0] arb_id;

  modport slave (
    input  rdy, flush,
    input  fet_req, fet_pc,
    input  lsb_req, lsb_op, lsb_addr, lsb_id,
    input  rob_req, rob_op, rob_addr, rob_val,
    input  mc_busy,
    output fet_gnt, lsb_gnt, rob_gnt,
    output arb_fet_enable, arb_lsb_enable, arb_rob_enable,
    output arb_pc, arb_addr, arb_val, arb_op, arb_id
  );

  modport master (
    output rdy, flush,
    output fet_req, fet_pc,
    output lsb_req, lsb_op, lsb_addr, lsb_id,
    output rob_req, rob_op, rob_addr, rob_val,
    output mc_busy,
    input  fet_gnt, lsb_gnt, rob_gnt,
    input  arb_fet_enable, arb_lsb_enable, arb_rob_enable,
    input  arb_pc, arb_addr, arb_val, arb_op, arb_id
  );

endinterface

// File: rtl/mem_arbiter_prio_sel.sv
// arb_prio_sel: combinational fixed-priority pick among the three memory
// requesters with a starvation override for fetch.
// Ports:
//   fet_req, lsb_req, rob_req : candidate requests (already flush-masked)
//   force_fet                 : fetch has waited too long, let it win
//   sel_o                     : one-hot winner, zero when nothing requests
module arb_prio_sel
  import mem_arbiter_pkg::*;
(
  input  logic     fet_req,
  input  logic     lsb_req,
  input  logic     rob_req,
  input  logic     force_fet,
  output req_vec_t sel_o
);

  always_comb begin
    sel_o = '0;
    if (force_fet && fet_req) begin
      sel_o[REQ_FET] = 1'b1;
    end else if (rob_req) begin
      sel_o[REQ_ROB] = 1'b1;
    end else if (lsb_req) begin
      sel_o[REQ_LSB] = 1'b1;
    end else if (fet_req) begin
      sel_o[REQ_FET] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: picks one of fetch / load buffer / committed store per
// transaction, registers its fields and hands it to the memory controller.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (requests, controller busy, grants, enables,
//          registered request fields)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request while the controller is not busy
// ISSUE | enable + grant of the selected requester are high
// WAIT  | controller working; leave when mc_busy drops
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  req_vec_t         sel_q, sel_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  arb_fields_t      fields_q, fields_d;

  req_vec_t pick;
  logic     fet_cand, lsb_cand, force_fet;
  logic     issue_live;

  // A flush leaves only the committed store eligible.
  assign fet_cand  = bus.fet_req & ~bus.flush;
  assign lsb_cand  = bus.lsb_req & ~bus.flush;
  assign force_fet = (starve_cnt_q == CNT_MAX);

  arb_prio_sel u_prio_sel (
    .fet_req   (fet_cand),
    .lsb_req   (lsb_cand),
    .rob_req   (bus.rob_req),
    .force_fet (force_fet),
    .sel_o     (pick)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    starve_cnt_d = starve_cnt_q;
    fields_d     = fields_q;
    if (bus.rdy) begin
      case (state_q)
        S_IDLE: begin
          if ((pick != '0) && !bus.mc_busy) begin
            state_d  = S_ISSUE;
            sel_d    = pick;
            fields_d = '0;
            if (pick[REQ_ROB]) begin
              fields_d.addr = bus.rob_addr;
              fields_d.val  = bus.rob_val;
              fields_d.op   = bus.rob_op;
            end else if (pick[REQ_LSB]) begin
              fields_d.addr = bus.lsb_addr;
              fields_d.op   = bus.lsb_op;
              fields_d.id   = bus.lsb_id;
            end else begin
              fields_d.pc   = bus.fet_pc;
            end
            if (pick[REQ_FET]) begin
              starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_MAX) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end
        end
        S_ISSUE: begin
          // A flushed fetch/load is dropped before the controller sees it.
          state_d = (bus.flush && !sel_q[REQ_ROB]) ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (!bus.mc_busy) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Starvation only counts while fetch is actually waiting.
      if (bus.flush || !bus.fet_req) begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      starve_cnt_q <= '0;
      fields_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      starve_cnt_q <= starve_cnt_d;
      fields_q     <= fields_d;
    end
  end

  // Enables decode straight from the registered state so reset clears them
  // immediately; the flush gate only applies while the pipeline is moving.
  assign issue_live = (state_q == S_ISSUE) &&
                      !(bus.rdy && bus.flush && !sel_q[REQ_ROB]);

  assign bus.arb_fet_enable = issue_live & sel_q[REQ_FET];
  assign bus.arb_lsb_enable = issue_live & sel_q[REQ_LSB];
  assign bus.arb_rob_enable = issue_live & sel_q[REQ_ROB];

  assign bus.fet_gnt = bus.arb_fet_enable;
  assign bus.lsb_gnt = bus.arb_lsb_enable;
  assign bus.rob_gnt = bus.arb_rob_enable;

  assign bus.arb_pc   = fields_q.pc;
  assign bus.arb_addr = fields_q.addr;
  assign bus.arb_val  = fields_q.val;
  assign bus.arb_op   = fields_q.op;
  assign bus.arb_id   = fields_q.id;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    int          who;
    arb_fields_t f;
    int          width;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  bit   active     = 0;
  int   width      = 0;
  exp_t cur;
  int   last_start = -100;
  int   start_cyc  = 0;
  int   busy_len   = 2;
  int   busy_left  = 0;
  bit   en_seen    = 0;
  bit   lsb_hold   = 0;
  int   rel, k;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] en_vec();
    return {bus.arb_rob_enable, bus.arb_lsb_enable, bus.arb_fet_enable};
  endfunction

  function automatic logic [2:0] gnt_vec();
    return {bus.rob_gnt, bus.lsb_gnt, bus.fet_gnt};
  endfunction

  function automatic exp_t mk(input int who, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] addr,
                              input logic [XLEN-1:0] val, input logic [INST_OP_WIDTH-1:0] op,
                              input logic [ROB_SIZE_WIDTH-1:0] id, input int w);
    exp_t e;
    e.who    = who;
    e.f.pc   = pc;
    e.f.addr = addr;
    e.f.val  = val;
    e.f.op   = op;
    e.f.id   = id;
    e.width  = w;
    return e;
  endfunction

  // Negedge monitor: scoreboard pop on each new enable pulse, requester
  // release after a consumed grant, and a simple controller busy model
  // (mc_busy rises the cycle after an accepted enable, lasts busy_len).
  task automatic monitor();
    logic [2:0] en;
    logic [2:0] gnt;
    logic [2:0] want;
    en  = en_vec();
    gnt = gnt_vec();
    if (!rst) begin
      active      = 0;
      busy_left   = 0;
      en_seen     = 0;
      last_start  = -100;
      bus.mc_busy = 1'b0;
      return;
    end
    if (en != 3'b000) begin
      if (!active) begin
        active    = 1;
        width     = 1;
        start_cyc = cyc;
        check_val("enable_onehot", 64'(is_onehot0(en)), 64'(1));
        check_val("gnt_eq_enable", 64'(gnt), 64'(en));
        check_val("grant_spacing_ge3", 64'((cyc - last_start) >= 3), 64'(1));
        last_start = cyc;
        if (exp_q.size() == 0) begin
          check_val("unexpected_grant", 64'(en), 64'(0));
          cur.width = 1;
        end else begin
          cur  = exp_q.pop_front();
          want = 3'(1 << cur.who);
          check_val("grant_who", 64'(en), 64'(want));
          check_val("arb_pc", 64'(bus.arb_pc), 64'(cur.f.pc));
          check_val("arb_addr", 64'(bus.arb_addr), 64'(cur.f.addr));
          check_val("arb_val", 64'(bus.arb_val), 64'(cur.f.val));
          check_val("arb_op", 64'(bus.arb_op), 64'(cur.f.op));
          check_val("arb_id", 64'(bus.arb_id), 64'(cur.f.id));
        end
      end else begin
        width++;
      end
      if (bus.rdy) begin
        if (en[REQ_FET]) bus.fet_req = 1'b0;
        if (en[REQ_LSB] && !lsb_hold) bus.lsb_req = 1'b0;
        if (en[REQ_ROB]) bus.rob_req = 1'b0;
      end
    end else if (active) begin
      active = 0;
      check_val("pulse_width", 64'(width), 64'(cur.width));
    end
    if (busy_left > 0) busy_left--;
    if (en_seen) busy_left = busy_len;
    en_seen     = (en != 3'b000) && bus.rdy;
    bus.mc_busy = (busy_left > 0);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || active) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_timeout", 64'(exp_q.size() + int'(active)), 64'(0));
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rdy = 1'b1;     bus.flush = 1'b0;    bus.mc_busy = 1'b0;
    bus.fet_req = 1'b0; bus.fet_pc = '0;
    bus.lsb_req = 1'b0; bus.lsb_op = '0;     bus.lsb_addr = '0; bus.lsb_id = '0;
    bus.rob_req = 1'b0; bus.rob_op = '0;     bus.rob_addr = '0; bus.rob_val = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_enables", 64'(en_vec()), 64'(0));
    check_val("rst_gnts", 64'(gnt_vec()), 64'(0));
    check_val("rst_fields", 64'({bus.arb_pc, bus.arb_addr} | 64'(bus.arb_val) | 64'(bus.arb_op) | 64'(bus.arb_id)), 64'(0));

    // Lone fetch granted on the first edge after reset release
    bus.fet_req = 1'b1; bus.fet_pc = 32'h1000;
    exp_q.push_back(mk(REQ_FET, 32'h1000, 0, 0, OP_NOP, 0, 1));
    @(posedge clk); #1 rst = 1'b1; rel = cyc;
    drain(20);
    check_val("first_grant_latency", 64'(start_cyc - rel), 64'(1));
    settle();

    // All three at once: rob, lsb, fet
    bus.rob_req = 1'b1; bus.rob_op = OP_SW; bus.rob_addr = 32'h2000; bus.rob_val = 32'hdead_beef;
    bus.lsb_req = 1'b1; bus.lsb_op = OP_LW; bus.lsb_addr = 32'h3000; bus.lsb_id = 4'd5;
    bus.fet_req = 1'b1; bus.fet_pc = 32'h1004;
    exp_q.push_back(mk(REQ_ROB, 0, 32'h2000, 32'hdead_beef, OP_SW, 0, 1));
    exp_q.push_back(mk(REQ_LSB, 0, 32'h3000, 0, OP_LW, 4'd5, 1));
    exp_q.push_back(mk(REQ_FET, 32'h1004, 0, 0, OP_NOP, 0, 1));
    drain(60);
    settle();

    // Continuous loads starve fetch: LIMIT load grants, then fetch
    lsb_hold = 1;
    bus.lsb_req = 1'b1; bus.lsb_op = OP_LB; bus.lsb_addr = 32'h4000; bus.lsb_id = 4'd2;
    bus.fet_req = 1'b1; bus.fet_pc = 32'h1008;
    for (int i = 0; i < LIMIT; i++) exp_q.push_back(mk(REQ_LSB, 0, 32'h4000, 0, OP_LB, 4'd2, 1));
    exp_q.push_back(mk(REQ_FET, 32'h1008, 0, 0, OP_NOP, 0, 1));
    drain(100);
    lsb_hold = 0; bus.lsb_req = 1'b0;
    settle();

    // Flush during a load ISSUE: suppressed, back to IDLE, reissued 2 cycles later
    bus.lsb_req = 1'b1; bus.lsb_op = OP_LH; bus.lsb_addr = 32'h5000; bus.lsb_id = 4'd7;
    @(posedge clk); #1 bus.flush = 1'b1; k = cyc;
    tick();
    check_val("flush_lsb_enable", 64'(bus.arb_lsb_enable), 64'(0));
    check_val("flush_lsb_gnt", 64'(bus.lsb_gnt), 64'(0));
    exp_q.push_back(mk(REQ_LSB, 0, 32'h5000, 0, OP_LH, 4'd7, 1));
    @(posedge clk); #1 bus.flush = 1'b0;
    drain(20);
    check_val("flush_reissue_cycle", 64'(start_cyc - k), 64'(2));
    settle();

    // Flush during a store ISSUE does not stop it
    bus.rob_req = 1'b1; bus.rob_op = OP_SB; bus.rob_addr = 32'h6000; bus.rob_val = 32'h55;
    exp_q.push_back(mk(REQ_ROB, 0, 32'h6000, 32'h55, OP_SB, 0, 1));
    @(posedge clk); #1 bus.flush = 1'b1;
    tick();
    @(posedge clk); #1 bus.flush = 1'b0;
    drain(20);
    settle();

    // Flush held in IDLE blocks load and fetch
    bus.flush = 1'b1;
    bus.lsb_req = 1'b1; bus.lsb_op = OP_LW; bus.lsb_addr = 32'h7000; bus.lsb_id = 4'd1;
    bus.fet_req = 1'b1; bus.fet_pc = 32'h100c;
    repeat (3) tick();
    check_val("flush_idle_block", 64'(en_vec()), 64'(0));
    bus.flush = 1'b0;
    exp_q.push_back(mk(REQ_LSB, 0, 32'h7000, 0, OP_LW, 4'd1, 1));
    exp_q.push_back(mk(REQ_FET, 32'h100c, 0, 0, OP_NOP, 0, 1));
    drain(40);
    settle();

    // Reset during WAIT with controller busy; pending fetch afterwards
    busy_len = 5;
    bus.lsb_req = 1'b1; bus.lsb_op = OP_LW; bus.lsb_addr = 32'h8000; bus.lsb_id = 4'd3;
    exp_q.push_back(mk(REQ_LSB, 0, 32'h8000, 0, OP_LW, 4'd3, 1));
    drain(20);
    bus.fet_req = 1'b1; bus.fet_pc = 32'h2000;
    tick();
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check_val("rst_wait_enables", 64'(en_vec()), 64'(0));
    check_val("rst_wait_gnts", 64'(gnt_vec()), 64'(0));
    check_val("rst_wait_addr", 64'(bus.arb_addr), 64'(0));
    check_val("rst_wait_op_id", 64'({bus.arb_op, bus.arb_id}), 64'(0));
    tick();
    busy_len = 2;
    exp_q.push_back(mk(REQ_FET, 32'h2000, 0, 0, OP_NOP, 0, 1));
    @(posedge clk); #1 rst = 1'b1; rel = cyc;
    drain(20);
    check_val("post_rst_grant_latency", 64'(start_cyc - rel), 64'(1));
    settle();

    // rdy low for 3 cycles during a store ISSUE stretches the single pulse
    bus.rob_req = 1'b1; bus.rob_op = OP_SW; bus.rob_addr = 32'h9000; bus.rob_val = 32'h1234;
    exp_q.push_back(mk(REQ_ROB, 0, 32'h9000, 32'h1234, OP_SW, 0, 4));
    @(posedge clk); #1 bus.rdy = 1'b0;
    tick();
    @(posedge clk);
    tick();
    @(posedge clk);
    tick();
    @(posedge clk); #1 bus.rdy = 1'b1;
    tick();
    drain(20);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
